// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix RAM arbiter and the matrix-multiply control unit.
package matrix_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RAM_D_DEF  = 512;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_P0   = 2'd1;
  localparam logic [1:0] OWNER_P1   = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Returns the winning port index; on a tie the port that did not own last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last_owner);
    if (r0 && r1) return ~last_owner;
    else if (r1)  return 1'b1;
    else          return 1'b0;
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter for the single-port matrix RAM, with bounded hold,
// optional burst lock and one-cycle read-data steering back to the issuing port.
module ram_port_arbiter
  import matrix_pkg::*;
#(
  parameter int data_w    = DATA_W_DEF,
  parameter int ram_d     = RAM_D_DEF,
  parameter int ram_add_w = $clog2(ram_d),
  parameter int max_hold  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ram_add_w-1:0] addr0,
  input  logic [ram_add_w-1:0] addr1,
  input  logic [data_w-1:0]    wdata0,
  input  logic [data_w-1:0]    wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [data_w-1:0]    rdata0,
  output logic [data_w-1:0]    rdata1,
  output logic                 ram_we,
  output logic [ram_add_w-1:0] ram_addr,
  output logic [data_w-1:0]    ram_w_data,
  input  logic [data_w-1:0]    ram_r_data,
  output logic [1:0]           owner
);

  localparam int HOLD_W = $clog2(max_hold + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(max_hold - 1);

  arb_state_e            state, state_nx;
  logic                  last_owner;
  logic [HOLD_W-1:0]     hold_cnt, hold_nx;
  logic                  acc0, acc1;
  logic                  rd_pend0, rd_pend1;
  logic [ram_add_w-1:0]  addr_q;
  logic [data_w-1:0]     wdata_q;

  assign gnt0 = (state == ARB_OWN0);
  assign gnt1 = (state == ARB_OWN1);
  assign acc0 = gnt0 && req0;
  assign acc1 = gnt1 && req1;

  always_comb begin
    owner = OWNER_NONE;
    if (gnt0) owner = OWNER_P0;
    if (gnt1) owner = OWNER_P1;
  end

  // When nobody accesses, the RAM sees the last address/data with write disabled.
  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_w_data = wdata_q;
    if (acc0) begin
      ram_we     = we0;
      ram_addr   = addr0;
      ram_w_data = wdata0;
    end else if (acc1) begin
      ram_we     = we1;
      ram_addr   = addr1;
      ram_w_data = wdata1;
    end
  end

  assign rvalid0 = rd_pend0;
  assign rvalid1 = rd_pend1;
  assign rdata0  = rd_pend0 ? ram_r_data : '0;
  assign rdata1  = rd_pend1 ? ram_r_data : '0;

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: begin
        if (req0 || req1)
          state_nx = rr_pick(req0, req1, last_owner) ? ARB_OWN1 : ARB_OWN0;
      end
      ARB_OWN0: begin
        if (!req0)
          state_nx = req1 ? ARB_OWN1 : ARB_IDLE;
        else if (req1 && !lock0 && hold_cnt == HOLD_LAST)
          state_nx = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!req1)
          state_nx = req0 ? ARB_OWN0 : ARB_IDLE;
        else if (req0 && !lock1 && hold_cnt == HOLD_LAST)
          state_nx = ARB_OWN0;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // Hold counts only contended access cycles of an unchanged owner, saturating.
  always_comb begin
    hold_nx = '0;
    if (state_nx == state && ((acc0 && req1) || (acc1 && req0)))
      hold_nx = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      rd_pend0   <= 1'b0;
      rd_pend1   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      if (state_nx == ARB_OWN0)      last_owner <= 1'b0;
      else if (state_nx == ARB_OWN1) last_owner <= 1'b1;
      rd_pend0 <= acc0 && !we0;
      rd_pend1 <= acc1 && !we1;
      addr_q   <= ram_addr;
      wdata_q  <= ram_w_data;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port matrix RAM between two requesters: port 0 is the host loader/readback path, port 1 is the matrix-multiply control unit.
- Grants one owner at a time using round-robin with a bounded hold, so a long compute burst cannot starve host readback.
- An optional lock input makes a burst atomic.
- Steers the RAM read data, with its one-cycle latency, back to whichever requester issued the read.

Parameters:
- data_w, 32, RAM word width.
- ram_d, 512, RAM depth in words.
- ram_add_w, $clog2(ram_d), RAM address width.
- max_hold, 16, maximum consecutive access cycles for the current owner while the other port is requesting and the owner's lock is low (must be ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req0, req1  in  1  request RAM access this cycle.
- lock0, lock1  in  1  hold ownership regardless of max_hold while req is high.
- we0, we1  in  1  write enable for the access.
- addr0, addr1  in  ram_add_w  access address.
- wdata0, wdata1  in  data_w  write data.
- gnt0, gnt1  out  1  registered grant; an access occurs in any cycle where reqN && gntN.
- rvalid0, rvalid1  out  1  read data valid for port N.
- rdata0, rdata1  out  data_w  read data for port N.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ram_add_w  RAM address.
- ram_w_data  out  data_w  RAM write data.
- ram_r_data  in  data_w  RAM read data, valid one cycle after the address is presented.
- owner  out  2  status: 0 = none, 1 = port 0, 2 = port 1.

Behaviour:
- Reset values: gnt0, gnt1, rvalid0, rvalid1, ram_we = 0; rdata0, rdata1, ram_addr, ram_w_data = 0; owner = 0; state = IDLE; last-owner pointer = 1, so port 0 wins the first tie; hold_cnt = 0.
- Reset mid-operation: a pending rvalid is dropped, and any access in the reset cycle has no effect.
- States:
  - IDLE: no grant.
  - OWN0: gnt0 = 1.
  - OWN1: gnt1 = 1.
- Grants are state-decoded outputs and change only on a clock edge.
- RAM mux, combinational:
  - In OWNn with reqn = 1: ram_addr/ram_w_data = addrn/wdatan and ram_we = wen.
  - Otherwise ram_we = 0; ram_addr and ram_w_data hold their last values.
- Read return: a read access (wen = 0) by port n in cycle t gives rvalidn = 1 in cycle t+1, with rdatan = ram_r_data. rdatan is combinational from ram_r_data and zero when rvalidn = 0.
- Writes produce no rvalid.
- IDLE transitions:
  - Only one port requesting → go to that port's OWN state.
  - Both requesting → go to the port not equal to the last-owner pointer.
  - Neither → stay in IDLE.
  - Latency from req to grant is one cycle.
- OWNn transitions, evaluated each edge, with m = the other port:
  - reqn = 0 and reqm = 1 → OWNm.
  - reqn = 0 and reqm = 0 → IDLE.
  - reqn = 1, reqm = 1, lockn = 0, hold_cnt = max_hold−1 → OWNm (forced handover).
  - Otherwise stay in OWNn.
- Handover between owners is direct, with no dead cycle.
- hold_cnt:
  - Increments on each access cycle in OWNn while reqm = 1.
  - Clears on any state change, and while reqm = 0.
  - Saturates at max_hold−1.
- Last-owner pointer updates to n on entry to OWNn.
- Simultaneous events:
  - The owner dropping req in the same cycle that a forced handover condition would fire resolves identically (→ OWNm).
  - A lock asserted on the same cycle as hold_cnt = max_hold−1 prevents the handover.
- A requester must hold req, addr, we and wdata stable until it sees its gnt. An ungranted request causes no RAM activity.
- Width rules: addresses pass through unmodified, with no wrap handling. hold_cnt is $clog2(max_hold+1) bits.

Decomposition:
- Shared package (matrix_pkg): owner encodings OWNER_NONE/P0/P1, the arbiter state constants, and data_w/ram_d defaults shared with the matrix multiply CU.
- No sub-module is needed beyond an optional rr_pick function; the block stays a single module of roughly 150–200 lines.

Test Plan:
- Reset, then req0 = 1 only, read addr 5 (RAM[5] = 0xDEADBEEF) → gnt0 = 1 at cycle 1, ram_addr = 5 and ram_we = 0 at cycle 1, rvalid0 = 1 and rdata0 = 0xDEADBEEF at cycle 2; rvalid1 stays 0.
- req0 and req1 asserted together from IDLE after reset → port 0 granted first. After port 0 releases and both re-request → port 1 is granted (round-robin).
- Port 1 streams 20 writes with lock1 = 0 while req0 is held high → exactly 16 (max_hold) port-1 writes, then gnt0 = 1 on the next cycle with no idle cycle. After port 0 drops req, port 1 resumes.
- Same stream with lock1 = 1 → all 20 port-1 writes complete before gnt0 rises.
- Port 1 reads addr 7 on the final cycle before a forced handover → rvalid1 = 1 with the correct data one cycle later, even though gnt0 is already 1; rvalid0 stays 0.
- Assert rst for one cycle in the middle of a port-0 read burst → all outputs 0 immediately (asynchronous), the pending rvalid0 is suppressed, state is IDLE, and the first grant after reset goes to port 0.
